// File: rtl/spi_frame_server.sv
// SPI peripheral that streams a frame buffer, a status byte or an ID byte, selected by an
// 8-bit opcode. Runs on hf_clk and oversamples the SPI pins through 2-flop synchronisers.
module spi_frame_server #(
  parameter int         DATA_WIDTH  = 16,
  parameter int         ADDR_WIDTH  = 14,
  parameter int         FRAME_WORDS = 768,
  parameter bit         CPOL        = 1'b0,
  parameter bit         CPHA        = 1'b0,
  parameter logic [7:0] DEVICE_ID   = 8'hA5
) (
  input  logic                  hf_clk,
  input  logic                  reset,
  input  logic                  sck,
  input  logic                  cs,
  input  logic                  copi,
  output logic                  cipo,
  output logic [ADDR_WIDTH-1:0] data_address,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  frame_ready,
  output logic                  busy,
  output logic                  frame_done
);
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_OPCODE = 3'd1;
  localparam logic [2:0] ST_FRAME  = 3'd2;
  localparam logic [2:0] ST_STATUS = 3'd3;
  localparam logic [2:0] ST_ID     = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(7);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);

  logic                  sck_meta, sck_sync, sck_prev;
  logic                  cs_meta, cs_sync, cs_prev;
  logic                  copi_meta, copi_sync;
  logic [2:0]            state;
  logic [7:0]            opcode;
  logic [2:0]            bit_cnt;
  logic [CNT_W-1:0]      rsp_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  inc_pending;

  logic sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_rise, cs_fall;
  logic [7:0] opcode_next;
  logic [DATA_WIDTH-1:0] load_word;

  assign sck_rise    = sck_sync & ~sck_prev;
  assign sck_fall    = ~sck_sync & sck_prev;
  assign lead_edge   = CPOL ? sck_fall : sck_rise;
  assign trail_edge  = CPOL ? sck_rise : sck_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_rise     = cs_sync & ~cs_prev;
  assign cs_fall     = ~cs_sync & cs_prev;
  assign opcode_next = {opcode[6:0], copi_sync};

  // Status and ID bytes ride in the top byte of the word-wide shift register.
  always_comb begin
    load_word = '0;
    case (state)
      ST_FRAME:  load_word = data;
      ST_STATUS: load_word = DATA_WIDTH'({frame_ready, 7'b0}) << (DATA_WIDTH - 8);
      ST_ID:     load_word = DATA_WIDTH'(DEVICE_ID) << (DATA_WIDTH - 8);
      default:   load_word = '0;
    endcase
  end

  // cs synchroniser resets high so that a cs already asserted at release lands in IGNORE.
  always_ff @(posedge hf_clk or posedge reset) begin
    if (reset) begin
      sck_meta     <= CPOL;
      sck_sync     <= CPOL;
      sck_prev     <= CPOL;
      cs_meta      <= 1'b1;
      cs_sync      <= 1'b1;
      cs_prev      <= 1'b1;
      copi_meta    <= 1'b0;
      copi_sync    <= 1'b0;
      state        <= ST_IGNORE;
      opcode       <= '0;
      bit_cnt      <= '0;
      rsp_cnt      <= '0;
      shreg        <= '0;
      inc_pending  <= 1'b0;
      cipo         <= 1'b0;
      data_address <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      sck_meta  <= sck;
      sck_sync  <= sck_meta;
      sck_prev  <= sck_sync;
      cs_meta   <= cs;
      cs_sync   <= cs_meta;
      cs_prev   <= cs_sync;
      copi_meta <= copi;
      copi_sync <= copi_meta;
      frame_done <= 1'b0;

      if (inc_pending) begin
        inc_pending  <= 1'b0;
        data_address <= (data_address == LAST_ADDR) ? '0 : data_address + 1'b1;
      end

      if (cs_fall) begin
        state        <= ST_IDLE;
        busy         <= 1'b0;
        cipo         <= 1'b0;
        data_address <= '0;
        inc_pending  <= 1'b0;
        rsp_cnt      <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            cipo <= 1'b0;
            if (cs_rise) begin
              state   <= ST_OPCODE;
              bit_cnt <= '0;
            end
          end
          ST_OPCODE: begin
            cipo <= 1'b0;
            if (sample_edge) begin
              opcode  <= opcode_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rsp_cnt <= '0;
                case (opcode_next)
                  8'h0B: begin
                    state        <= ST_FRAME;
                    data_address <= '0;
                    inc_pending  <= 1'b0;
                    busy         <= 1'b1;
                  end
                  8'h05:   state <= ST_STATUS;
                  8'h9F:   state <= ST_ID;
                  default: state <= ST_IGNORE;
                endcase
              end
            end
          end
          ST_FRAME, ST_STATUS, ST_ID: begin
            if (shift_edge) begin
              if (rsp_cnt == '0) begin
                cipo    <= load_word[DATA_WIDTH-1];
                shreg   <= load_word << 1;
                rsp_cnt <= (state == ST_FRAME) ? WORD_LAST : BYTE_LAST;
                if (state == ST_FRAME) begin
                  inc_pending <= 1'b1;
                  frame_done  <= (data_address == LAST_ADDR);
                end
              end else begin
                cipo    <= shreg[DATA_WIDTH-1];
                shreg   <= shreg << 1;
                rsp_cnt <= rsp_cnt - 1'b1;
              end
            end
          end
          default: cipo <= 1'b0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_frame_server.sv
// Drives five spi_frame_server instances (four SPI modes, one 4-word frame) from one
// controller model and checks the received words against hand-computed vectors.
module tb_spi_frame_server;
  localparam int NDUT = 5;
  localparam int H    = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic base_sck = 1'b0;
  logic cs = 1'b0;
  logic copi = 1'b0;
  logic frame_ready = 1'b0;

  logic [NDUT-1:0] sck_v, cipo_v, busy_v, fd_v, addr_zero_v, addr_over_v;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    localparam bit P_CPOL = (gi == 2) || (gi == 3);
    localparam bit P_CPHA = (gi == 1) || (gi == 3);
    localparam int P_FW   = (gi == 4) ? 4 : 768;
    logic [13:0] addr;
    logic [15:0] rdata;
    assign sck_v[gi] = base_sck ^ P_CPOL;
    spi_frame_server #(
      .DATA_WIDTH(16), .ADDR_WIDTH(14), .FRAME_WORDS(P_FW),
      .CPOL(P_CPOL), .CPHA(P_CPHA), .DEVICE_ID(8'hA5)
    ) u_dut (
      .hf_clk(clk), .reset(reset), .sck(sck_v[gi]), .cs(cs), .copi(copi),
      .cipo(cipo_v[gi]), .data_address(addr), .data(rdata),
      .frame_ready(frame_ready), .busy(busy_v[gi]), .frame_done(fd_v[gi])
    );
    // memory[i] = i + 1 with a one-cycle registered read
    always @(posedge clk) rdata <= 16'(addr) + 16'd1;
    assign addr_zero_v[gi] = (addr == 14'd0);
    assign addr_over_v[gi] = (int'(addr) >= P_FW);
  end

  int fd_cnt [NDUT] = '{default: 0};
  int fd_wide = 0;
  int addr_over_cnt = 0;
  logic [NDUT-1:0] fd_prev = '0;

  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) fd_cnt[k] <= fd_cnt[k] + (fd_v[k] ? 1 : 0);
    fd_wide       <= fd_wide + (((fd_v & fd_prev) != '0) ? 1 : 0);
    addr_over_cnt <= addr_over_cnt + ((addr_over_v != '0) ? 1 : 0);
    fd_prev       <= fd_v;
  end

  typedef struct {
    string       name;
    logic [7:0]  op;
    int          nrsp;
    logic        fr;
    logic [95:0] exp_main;
    logic [95:0] exp_wrap;
    logic [4:0]  busy_exp;
    int          fd_main;
    int          fd_wrap;
  } vec_t;

  vec_t tbl [6];
  logic [95:0] rx [NDUT];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bit cycle: CPHA=0 instances sampled just before the rise, CPHA=1 just before the fall.
  task automatic spi_bit(input logic b, input int idx);
    repeat (2) @(negedge clk);
    copi = b;
    repeat (H - 2) @(negedge clk);
    if (idx >= 0)
      for (int k = 0; k < NDUT; k++) if (k != 1 && k != 3) rx[k][95-idx] = cipo_v[k];
    base_sck = 1'b1;
    repeat (H) @(negedge clk);
    if (idx >= 0)
      for (int k = 0; k < NDUT; k++) if (k == 1 || k == 3) rx[k][95-idx] = cipo_v[k];
    base_sck = 1'b0;
  endtask

  task automatic send_op(input logic [7:0] op);
    for (int i = 0; i < 8; i++) spi_bit(op[7-i], -1);
  endtask

  task automatic end_tx(input logic [4:0] bexp, input string name);
    repeat (4) @(negedge clk);
    chk({name, "_busy_hold"}, 96'(busy_v), 96'(bexp));
    cs = 1'b0;
    repeat (2) @(negedge clk);
    chk({name, "_busy_cs2"}, 96'(busy_v), 96'(bexp));
    @(negedge clk);
    chk({name, "_busy_cs3"}, 96'(busy_v), 96'(0));
    repeat (8) @(negedge clk);
  endtask

  task automatic run_entry(input int e);
    int fd0 [NDUT];
    frame_ready = tbl[e].fr;
    for (int k = 0; k < NDUT; k++) begin
      rx[k]  = '0;
      fd0[k] = fd_cnt[k];
    end
    cs = 1'b1;
    repeat (4) @(negedge clk);
    send_op(tbl[e].op);
    for (int i = 0; i < tbl[e].nrsp; i++) spi_bit(1'b0, i);
    end_tx(tbl[e].busy_exp, tbl[e].name);
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("%s_data_dut%0d", tbl[e].name, k), rx[k],
          (k == 4) ? tbl[e].exp_wrap : tbl[e].exp_main);
      chk($sformatf("%s_frame_done_dut%0d", tbl[e].name, k), 96'(fd_cnt[k] - fd0[k]),
          96'((k == 4) ? tbl[e].fd_wrap : tbl[e].fd_main));
    end
  endtask

  initial begin
    tbl[0] = '{"frame", 8'h0B, 96, 1'b0,
               {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006},
               {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0001, 16'h0002},
               5'b11111, 0, 1};
    tbl[1] = '{"status_rdy", 8'h05, 16, 1'b1, {16'h8080, 80'h0}, {16'h8080, 80'h0},
               5'b00000, 0, 0};
    tbl[2] = '{"status_nrdy", 8'h05, 16, 1'b0, 96'h0, 96'h0, 5'b00000, 0, 0};
    tbl[3] = '{"id", 8'h9F, 16, 1'b0, {16'hA5A5, 80'h0}, {16'hA5A5, 80'h0},
               5'b00000, 0, 0};
    tbl[4] = '{"unknown", 8'h00, 16, 1'b0, 96'h0, 96'h0, 5'b00000, 0, 0};
    tbl[5] = '{"restart", 8'h0B, 16, 1'b0, {16'h0001, 80'h0}, {16'h0001, 80'h0},
               5'b11111, 0, 0};

    repeat (3) @(negedge clk);
    chk("reset_busy", 96'(busy_v), 96'(0));
    chk("reset_cipo", 96'(cipo_v), 96'(0));
    chk("reset_addr_zero", 96'(addr_zero_v), 96'(5'b11111));
    chk("reset_frame_done", 96'(fd_v), 96'(0));
    reset = 1'b0;
    repeat (6) @(negedge clk);

    for (int e = 0; e < 5; e++) run_entry(e);

    // Abort: opcode plus 7 response bits, then cs drops; next read must restart at word 0.
    cs = 1'b1;
    repeat (4) @(negedge clk);
    send_op(8'h0B);
    for (int i = 0; i < 7; i++) spi_bit(1'b0, -1);
    end_tx(5'b11111, "abort");
    run_entry(5);

    // Reset pulsed mid-word with cs held high.
    cs = 1'b1;
    repeat (4) @(negedge clk);
    send_op(8'h0B);
    for (int i = 0; i < 5; i++) spi_bit(1'b0, -1);
    repeat (3) @(negedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_busy", 96'(busy_v), 96'(0));
    chk("async_rst_addr_zero", 96'(addr_zero_v), 96'(5'b11111));
    chk("async_rst_cipo", 96'(cipo_v), 96'(0));
    chk("async_rst_frame_done", 96'(fd_v), 96'(0));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < NDUT; k++) rx[k] = '0;
    begin
      logic [15:0] pat;
      pat = 16'h9FFF;
      for (int i = 0; i < 16; i++) spi_bit(pat[15-i], i);
    end
    for (int k = 0; k < NDUT; k++) chk($sformatf("post_rst_ignore_dut%0d", k), rx[k], 96'h0);
    end_tx(5'b00000, "post_rst");
    run_entry(3);

    chk("frame_done_width", 96'(fd_wide), 96'(0));
    chk("addr_in_range", 96'(addr_over_cnt), 96'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
